cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
//  Shares one cache CPU-side port (Avalon-style read/write/waitrequest/readdata_valid) between
//  the instruction fetch path (s0, read-only) and the load/store unit (s1, read/write).
//  Sits between fetch/LSU and the cache; tracks outstanding reads so every readdata_valid
//  is routed to the requester that issued it. Fetch flush/jump discards stale fetch responses.
// PARAMETERS
//  ADDR_W   25  cache word-address width (matches `CacheAddrBus)
//  DATA_W   32  data width (matches `CacheDataBus)
//  BE_W     4   byte-enable width (matches `CacheByteBus)
//  MAX_OUT  4   max outstanding reads (tag FIFO depth, power of 2, >=2)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous active-high reset
//  s0_addr      in   ADDR_W  fetch read address
//  s0_read      in   1       fetch read request
//  s0_flush     in   1       fetch jump/flush: discard all queued fetch responses
//  s0_waitreq   out  1       fetch request not accepted this cycle
//  s0_rvalid    out  1       fetch read data valid
//  s1_addr      in   ADDR_W  LSU address
//  s1_byte_en   in   BE_W    LSU write byte mask
//  s1_wdata     in   DATA_W  LSU write data
//  s1_read      in   1       LSU read request
//  s1_write     in   1       LSU write request (never with s1_read)
//  s1_waitreq   out  1       LSU request not accepted this cycle
//  s1_rvalid    out  1       LSU read data valid
//  rdata        out  DATA_W  read data, broadcast to both requesters (= m_readdata)
//  m_addr/m_byte_en/m_wdata  out  ADDR_W/BE_W/DATA_W  command to cache
//  m_read/m_write  out 1     command strobes to cache
//  m_readdata   in   DATA_W  cache read data
//  m_rvalid     in   1       cache read data valid
//  m_waitreq    in   1       cache stall
//  err_o        out  1       sticky: m_rvalid received with no outstanding tag
// BEHAVIOUR
//  - Reset: m_read=m_write=0, s*_rvalid=0, err_o=0, owner=NONE, tag FIFO empty; s*_waitreq=1 only
//    while a request is present (combinational). All counters/pointers cleared; queued tags lost.
//  - States (owner reg): IDLE, HOLD_S0, HOLD_S1. IDLE: pick winner combinationally, drive m_*.
//    If m_waitreq=1 enter HOLD_<winner>: winner's command stays on m_* and no re-arbitration until
//    accepted (m_waitreq=0) -> IDLE. Requester must hold its command while its waitreq=1.
//  - Accept = (m_read|m_write)&~m_waitreq; accepted requester sees waitreq=0 same cycle; zero added latency.
//  - Eligibility: read needs tag FIFO not full (a pop in same cycle does NOT free a slot); writes
//    always eligible; s0 ineligible while s0_flush=1. HOLD_S0 aborted by s0_flush only if cache
//    has not accepted (m_read dropped, -> IDLE).
//  - Priority without macro: fixed, s1 (LSU) over s0.
//  - Accepted read pushes tag {discard=0, id}; writes push nothing. m_rvalid pops head; drives
//    s<id>_rvalid=1 same cycle unless discard=1 (then dropped silently).
//  - s0_flush=1: every queued tag with id=0 gets discard=1 (incl. one popped same cycle).
//  - m_rvalid with FIFO empty: ignored, err_o<=1 until rst.
//  - Outputs m_addr/m_wdata/m_byte_en = 0 when idle with no request; byte_en forced 0 for reads.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: round-robin; last_grant reg flips to the other port after each
//    accept when both eligible; reset last_grant=s1 (so s0 wins first tie).
//  Undefined: fixed priority s1>s0 (fetch may starve under continuous LSU traffic).
// STRUCTURE
//  Shared defines header: `CacheAddrBus, `CacheDataBus, `CacheByteBus, owner encodings
//  ARB_OWN_NONE/S0/S1, tag layout {discard,id}.
//  Sub-module arb_tag_fifo (MAX_OUT x 2 bit, push/pop/full/empty, bulk discard-mark input).
// TESTING
//  1 s0_read@0x10, s1_read@0x20 same cycle, m_waitreq=0 -> s1 accepted first, s0 next cycle;
//    two m_rvalid (0xAAAA,0xBBBB) -> s1_rvalid then s0_rvalid with matching rdata.
//  2 s1_write@0x30 be=0xF with m_waitreq=1 for 3 cycles -> m_* stable, s0_read blocked, accept cycle 4.
//  3 Issue 4 s0 reads (MAX_OUT=4) no responses -> 5th read waitreq=1; s1_write still accepted.
//  4 2 fetch reads outstanding, s0_flush 1 cycle -> both m_rvalid dropped, s0_rvalid stays 0.
//  5 m_rvalid with empty FIFO -> err_o=1, held; rst -> err_o=0.
//  6 ARB_ROUND_ROBIN_EN: both ports read continuously -> grants alternate s0,s1,s0,s1.

Source files
------------

// File: rtl/cache_port_arbiter_pkg.sv
// Shared bus widths, owner encodings and outstanding-read tag layout for the cache port arbiter.
package cache_port_arbiter_pkg;

    localparam int CACHE_ADDR_BUS = 25;
    localparam int CACHE_DATA_BUS = 32;
    localparam int CACHE_BYTE_BUS = 4;

    localparam logic [1:0] ARB_OWN_NONE = 2'd0;
    localparam logic [1:0] ARB_OWN_S0   = 2'd1;
    localparam logic [1:0] ARB_OWN_S1   = 2'd2;

    localparam logic ARB_ID_S0 = 1'b0;
    localparam logic ARB_ID_S1 = 1'b1;

    typedef struct packed {
        logic discard;
        logic id;
    } arb_tag_t;

endpackage

// File: rtl/cache_port_arbiter_tag_fifo.sv
// Outstanding-read tag FIFO; a flush marks every queued fetch tag as discard in one cycle.
module arb_tag_fifo
    import cache_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     push_id,
    input  logic     pop,
    input  logic     discard_s0,
    output arb_tag_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic [DEPTH*2-1:0] tags_flat;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // Entries live in flops rather than RAM because the discard mark touches all of them at once.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            arb_tag_t entry_reg;

            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push_ok && wr_ptr_reg == PTR_W'(gi)) begin
                    entry_reg <= '{discard: 1'b0, id: push_id};
                end else if (discard_s0 && entry_reg.id == ARB_ID_S0) begin
                    entry_reg.discard <= 1'b1;
                end
            end

            assign tags_flat[gi*2 +: 2] = entry_reg;
        end
    endgenerate

    assign head = tags_flat[{rd_ptr_reg, 1'b0} +: 2];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache CPU port between fetch (s0) and LSU (s1), routing read responses by tag.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority LSU over fetch.
module cache_port_arbiter
    import cache_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = CACHE_ADDR_BUS,
    parameter int DATA_W  = CACHE_DATA_BUS,
    parameter int BE_W    = CACHE_BYTE_BUS,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic              s0_read,
    input  logic              s0_flush,
    output logic              s0_waitreq,
    output logic              s0_rvalid,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [BE_W-1:0]   s1_byte_en,
    input  logic [DATA_W-1:0] s1_wdata,
    input  logic              s1_read,
    input  logic              s1_write,
    output logic              s1_waitreq,
    output logic              s1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic [BE_W-1:0]   m_byte_en,
    output logic [DATA_W-1:0] m_wdata,
    output logic              m_read,
    output logic              m_write,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_rvalid,
    input  logic              m_waitreq,
    output logic              err_o
);

    logic [1:0] owner_reg;
    logic [1:0] owner_next;
    logic       err_reg;
    logic       fifo_full;
    logic       fifo_empty;
    arb_tag_t   head_tag;
    logic       s0_elig;
    logic       s1_elig;
    logic       grant_s0;
    logic       grant_s1;
    logic       accept;
    logic       tag_pop;
    logic       head_dropped;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_reg;
`endif

    // A pop in the same cycle does not free a slot: full is taken from the registered count.
    assign s0_elig = s0_read & ~s0_flush & ~fifo_full;
    assign s1_elig = s1_write | (s1_read & ~fifo_full);

    always_comb begin
        grant_s0 = 1'b0;
        grant_s1 = 1'b0;
        if (!rst) begin
            case (owner_reg)
                ARB_OWN_S0: grant_s0 = s0_read & ~s0_flush;
                ARB_OWN_S1: grant_s1 = s1_read | s1_write;
                default: begin
`ifdef ARB_ROUND_ROBIN_EN
                    if (s0_elig && s1_elig) begin
                        grant_s0 = (last_grant_reg == ARB_ID_S1);
                        grant_s1 = (last_grant_reg == ARB_ID_S0);
                    end else begin
                        grant_s0 = s0_elig;
                        grant_s1 = s1_elig;
                    end
`else
                    grant_s1 = s1_elig;
                    grant_s0 = s0_elig & ~s1_elig;
`endif
                end
            endcase
        end
    end

    assign m_read    = grant_s0 | (grant_s1 & s1_read);
    assign m_write   = grant_s1 & s1_write;
    assign m_addr    = grant_s0 ? s0_addr : (grant_s1 ? s1_addr : '0);
    assign m_wdata   = m_write ? s1_wdata : '0;
    assign m_byte_en = m_write ? s1_byte_en : '0;
    assign accept    = (m_read | m_write) & ~m_waitreq;

    assign s0_waitreq = s0_read & ~(grant_s0 & accept);
    assign s1_waitreq = (s1_read | s1_write) & ~(grant_s1 & accept);

    always_comb begin
        owner_next = owner_reg;
        case (owner_reg)
            ARB_OWN_NONE: begin
                if (grant_s0 && m_waitreq) begin
                    owner_next = ARB_OWN_S0;
                end else if (grant_s1 && m_waitreq) begin
                    owner_next = ARB_OWN_S1;
                end
            end
            ARB_OWN_S0: if (!grant_s0 || accept) owner_next = ARB_OWN_NONE;
            ARB_OWN_S1: if (!grant_s1 || accept) owner_next = ARB_OWN_NONE;
            default:    owner_next = ARB_OWN_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_reg <= ARB_OWN_NONE;
            err_reg   <= 1'b0;
        end else begin
            owner_reg <= owner_next;
            if (m_rvalid && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_reg <= ARB_ID_S1;
        end else if (accept && s0_elig && s1_elig) begin
            last_grant_reg <= grant_s1;
        end
    end
`endif

    arb_tag_fifo #(
        .DEPTH(MAX_OUT)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept & m_read),
        .push_id   (grant_s1),
        .pop       (tag_pop),
        .discard_s0(s0_flush),
        .head      (head_tag),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The head tag can be discarded by a flush arriving in the very cycle it is popped.
    assign tag_pop      = m_rvalid & ~fifo_empty & ~rst;
    assign head_dropped = head_tag.discard | (s0_flush & (head_tag.id == ARB_ID_S0));
    assign s0_rvalid    = tag_pop & (head_tag.id == ARB_ID_S0) & ~head_dropped;
    assign s1_rvalid    = tag_pop & (head_tag.id == ARB_ID_S1) & ~head_tag.discard;
    assign rdata        = m_readdata;
    assign err_o        = err_reg;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter; inputs change on negedge, outputs are checked 1 ns later.
module tb_cache_port_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [ADDR_W-1:0] s0_addr;
    logic              s0_read;
    logic              s0_flush;
    logic              s0_waitreq;
    logic              s0_rvalid;
    logic [ADDR_W-1:0] s1_addr;
    logic [BE_W-1:0]   s1_byte_en;
    logic [DATA_W-1:0] s1_wdata;
    logic              s1_read;
    logic              s1_write;
    logic              s1_waitreq;
    logic              s1_rvalid;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] m_addr;
    logic [BE_W-1:0]   m_byte_en;
    logic [DATA_W-1:0] m_wdata;
    logic              m_read;
    logic              m_write;
    logic [DATA_W-1:0] m_readdata;
    logic              m_rvalid;
    logic              m_waitreq;
    logic              err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .BE_W   (BE_W),
        .MAX_OUT(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s0_addr   (s0_addr),
        .s0_read   (s0_read),
        .s0_flush  (s0_flush),
        .s0_waitreq(s0_waitreq),
        .s0_rvalid (s0_rvalid),
        .s1_addr   (s1_addr),
        .s1_byte_en(s1_byte_en),
        .s1_wdata  (s1_wdata),
        .s1_read   (s1_read),
        .s1_write  (s1_write),
        .s1_waitreq(s1_waitreq),
        .s1_rvalid (s1_rvalid),
        .rdata     (rdata),
        .m_addr    (m_addr),
        .m_byte_en (m_byte_en),
        .m_wdata   (m_wdata),
        .m_read    (m_read),
        .m_write   (m_write),
        .m_readdata(m_readdata),
        .m_rvalid  (m_rvalid),
        .m_waitreq (m_waitreq),
        .err_o     (err_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One line per accepted command and per delivered response.
    always @(posedge clk) begin
        if (!rst) begin
            if ((m_read || m_write) && !m_waitreq)
                $display("cmd %s addr=0x%0h be=0x%0h wdata=0x%0h", m_write ? "wr" : "rd",
                         m_addr, m_byte_en, m_wdata);
            if (s0_rvalid || s1_rvalid)
                $display("rsp s%0d rdata=0x%0h", s1_rvalid ? 1 : 0, rdata);
        end
    end

    initial begin
        rst        = 1'b1;
        s0_addr    = '0;
        s0_read    = 1'b0;
        s0_flush   = 1'b0;
        s1_addr    = '0;
        s1_byte_en = '0;
        s1_wdata   = '0;
        s1_read    = 1'b0;
        s1_write   = 1'b0;
        m_readdata = '0;
        m_rvalid   = 1'b0;
        m_waitreq  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_m_read", 32'(m_read), 0);
        check("rst_m_write", 32'(m_write), 0);
        check("rst_s0_waitreq", 32'(s0_waitreq), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_m_addr", 32'(m_addr), 0);

        // 1: simultaneous reads, LSU first, responses routed in order
        @(negedge clk);
        s0_read = 1'b1; s0_addr = 25'h10;
        s1_read = 1'b1; s1_addr = 25'h20;
        #1;
        check("t1_m_read", 32'(m_read), 1);
        check("t1_addr_s1", 32'(m_addr), 32'h20);
        check("t1_s1_waitreq", 32'(s1_waitreq), 0);
        check("t1_s0_waitreq", 32'(s0_waitreq), 1);
        @(negedge clk);
        s1_read = 1'b0;
        #1;
        check("t1_addr_s0", 32'(m_addr), 32'h10);
        check("t1_s0_accept", 32'(s0_waitreq), 0);
        @(negedge clk);
        s0_read = 1'b0; m_rvalid = 1'b1; m_readdata = 32'hAAAA;
        #1;
        check("t1_rsp1_s1", 32'(s1_rvalid), 1);
        check("t1_rsp1_s0", 32'(s0_rvalid), 0);
        check("t1_rsp1_data", rdata, 32'hAAAA);
        @(negedge clk);
        m_readdata = 32'hBBBB;
        #1;
        check("t1_rsp2_s0", 32'(s0_rvalid), 1);
        check("t1_rsp2_s1", 32'(s1_rvalid), 0);
        check("t1_rsp2_data", rdata, 32'hBBBB);
        @(negedge clk);
        m_rvalid = 1'b0;

        // 2: stalled write holds the port for 3 cycles, accepted on the 4th
        s1_write = 1'b1; s1_addr = 25'h30; s1_byte_en = 4'hF; s1_wdata = 32'h12345678;
        s0_read = 1'b1; s0_addr = 25'h40; m_waitreq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t2_hold_write", 32'(m_write), 1);
            check("t2_hold_addr", 32'(m_addr), 32'h30);
            check("t2_hold_be", 32'(m_byte_en), 32'hF);
            check("t2_hold_wdata", m_wdata, 32'h12345678);
            check("t2_s1_waitreq", 32'(s1_waitreq), 1);
            check("t2_s0_blocked", 32'(s0_waitreq), 1);
            @(negedge clk);
        end
        m_waitreq = 1'b0;
        #1;
        check("t2_accept_write", 32'(m_write), 1);
        check("t2_accept_waitreq", 32'(s1_waitreq), 0);
        check("t2_s0_still_wait", 32'(s0_waitreq), 1);
        @(negedge clk);
        s1_write = 1'b0;
        #1;
        check("t2_s0_read", 32'(m_read), 1);
        check("t2_s0_addr", 32'(m_addr), 32'h40);
        check("t2_read_be_zero", 32'(m_byte_en), 0);
        check("t2_s0_accept", 32'(s0_waitreq), 0);
        @(negedge clk);
        s0_read = 1'b0; m_rvalid = 1'b1; m_readdata = 32'h5555;
        #1;
        check("t2_s0_rvalid", 32'(s0_rvalid), 1);
        @(negedge clk);
        m_rvalid = 1'b0;

        // 3: four fetch reads fill the tag FIFO
        for (int i = 0; i < 4; i++) begin
            s0_read = 1'b1; s0_addr = 25'(32'h100 + i);
            #1;
            check("t3_fill_accept", 32'(s0_waitreq), 0);
            @(negedge clk);
        end
        s0_addr = 25'h104;
        #1;
        check("t3_full_waitreq", 32'(s0_waitreq), 1);
        check("t3_full_no_read", 32'(m_read), 0);
        s1_write = 1'b1; s1_addr = 25'h50; s1_byte_en = 4'h3; s1_wdata = 32'hCAFE;
        #1;
        check("t3_write_ok", 32'(m_write), 1);
        check("t3_write_accept", 32'(s1_waitreq), 0);
        check("t3_s0_still_full", 32'(s0_waitreq), 1);
        @(negedge clk);
        s1_write = 1'b0; m_rvalid = 1'b1; m_readdata = 32'h100;
        #1;
        check("t3_pop_no_free", 32'(s0_waitreq), 1);
        check("t3_drain_first", 32'(s0_rvalid), 1);
        @(negedge clk);
        s0_read = 1'b0;
        for (int i = 0; i < 3; i++) begin
            m_readdata = 32'(32'h101 + i);
            #1;
            check("t3_drain", 32'(s0_rvalid), 1);
            @(negedge clk);
        end
        m_rvalid = 1'b0;

        // 4: flush discards queued fetch responses
        s0_read = 1'b1; s0_addr = 25'h200;
        #1;
        check("t4_rd0_accept", 32'(s0_waitreq), 0);
        @(negedge clk);
        s0_addr = 25'h201;
        #1;
        check("t4_rd1_accept", 32'(s0_waitreq), 0);
        @(negedge clk);
        s0_read = 1'b0; s0_flush = 1'b1;
        @(negedge clk);
        s0_flush = 1'b0; m_rvalid = 1'b1; m_readdata = 32'hDEAD;
        #1;
        check("t4_drop0_s0", 32'(s0_rvalid), 0);
        check("t4_drop0_s1", 32'(s1_rvalid), 0);
        @(negedge clk);
        #1;
        check("t4_drop1_s0", 32'(s0_rvalid), 0);
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        check("t4_no_err", 32'(err_o), 0);
        s0_read = 1'b1; s0_addr = 25'h300;
        @(negedge clk);
        s0_read = 1'b0; m_rvalid = 1'b1; s0_flush = 1'b1;
        #1;
        check("t4_flush_same_pop", 32'(s0_rvalid), 0);
        @(negedge clk);
        m_rvalid = 1'b0; s0_flush = 1'b0;
        #1;
        check("t4_no_err2", 32'(err_o), 0);

        // 5: response with nothing outstanding sets sticky error
        @(negedge clk);
        m_rvalid = 1'b1;
        #1;
        check("t5_orphan_s0", 32'(s0_rvalid), 0);
        check("t5_orphan_s1", 32'(s1_rvalid), 0);
        @(negedge clk);
        m_rvalid = 1'b0;
        #1;
        check("t5_err_set", 32'(err_o), 1);
        @(negedge clk);
        #1;
        check("t5_err_sticky", 32'(err_o), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_err_cleared", 32'(err_o), 0);

        // 6: both ports reading back to back
        @(negedge clk);
        s0_read = 1'b1; s0_addr = 25'h400;
        s1_read = 1'b1; s1_addr = 25'h500;
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t6_rr_s0_wait", 32'(s0_waitreq), (i % 2 == 0) ? 0 : 1);
            check("t6_rr_s1_wait", 32'(s1_waitreq), (i % 2 == 0) ? 1 : 0);
            check("t6_rr_addr", 32'(m_addr), (i % 2 == 0) ? 32'h400 : 32'h500);
            @(negedge clk);
        end
        s0_read = 1'b0; s1_read = 1'b0; m_rvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("t6_rr_rsp_s0", 32'(s0_rvalid), (i % 2 == 0) ? 1 : 0);
            check("t6_rr_rsp_s1", 32'(s1_rvalid), (i % 2 == 0) ? 0 : 1);
            @(negedge clk);
        end
`else
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t6_fix_s1_wait", 32'(s1_waitreq), 0);
            check("t6_fix_s0_wait", 32'(s0_waitreq), 1);
            check("t6_fix_addr", 32'(m_addr), 32'h500);
            @(negedge clk);
        end
        s0_read = 1'b0; s1_read = 1'b0; m_rvalid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("t6_fix_rsp_s1", 32'(s1_rvalid), 1);
            check("t6_fix_rsp_s0", 32'(s0_rvalid), 0);
            @(negedge clk);
        end
`endif
        m_rvalid = 1'b0;
        #1;
        check("t6_end_no_err", 32'(err_o), 0);

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
